// File: rtl/motor_sequencer.sv
// motor_sequencer: H-bridge sequencing with dead-time, soft-start ramp,
// filtered overcurrent shutdown, retry and lockout.
module motor_sequencer #(
  parameter int DEAD_CYCLES       = 1000,
  parameter int RAMP_STEP_CYCLES  = 25000,
  parameter int FAULT_HOLD_CYCLES = 100000,
  parameter int COMP_FILTER       = 4,
  parameter int MAX_RETRY         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fwd_req,
  input  logic       bwd_req,
  input  logic [2:0] duty_req,
  input  logic       comp_a,
  input  logic       comp_b,
  input  logic       pwm_pulse,
  output logic [2:0] duty_cmd,
  output logic [3:0] hb_in,
  output logic       en_a,
  output logic       en_b,
  output logic       fault,
  output logic       lockout,
  output logic [2:0] state
);

  localparam int M1   = (DEAD_CYCLES > RAMP_STEP_CYCLES) ? DEAD_CYCLES : RAMP_STEP_CYCLES;
  localparam int CMAX = (M1 > FAULT_HOLD_CYCLES) ? M1 : FAULT_HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(COMP_FILTER + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DEAD = 3'd1, S_RAMP = 3'd2,
    S_RUN  = 3'd3, S_FAULT = 3'd4, S_LOCKOUT = 3'd5
  } state_e;

  typedef enum logic [1:0] {D_STOP = 2'd0, D_FWD = 2'd1, D_BWD = 2'd2} dir_e;

  // bit order: {comp_b, comp_a, bwd, fwd, enable}
  logic [4:0] sync1_q, sync2_q;
  logic [FW-1:0] flt_q;
  state_e state_q, state_d;
  dir_e dir_q, dir_d, tgt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] duty_q, duty_d, dreq;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0] hb_q, hb_d;
  logic gate_q, gate_d, drive;
  logic en_s, oc;

  // two-flop synchronizers for all asynchronous switch/comparator inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {comp_b, comp_a, bwd_req, fwd_req, enable};
      sync2_q <= sync1_q;
    end
  end

  assign en_s = sync2_q[0];
  assign oc   = (flt_q == FW'(COMP_FILTER));
  assign dreq = (duty_req > 3'd4) ? 3'd4 : duty_req;

  // overcurrent filter: count consecutive high cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flt_q <= '0;
    else if (sync2_q[3] | sync2_q[4]) begin
      if (!oc) flt_q <= flt_q + FW'(1);
    end else flt_q <= '0;
  end

  // requested direction; both or neither asserted means stop
  always_comb begin
    tgt = D_STOP;
    if (sync2_q[1] && !sync2_q[2]) tgt = D_FWD;
    else if (sync2_q[2] && !sync2_q[1]) tgt = D_BWD;
  end

  // next-state logic; enable low overrides everything and clears retries
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    retry_d = retry_q;
    if (!en_s) begin
      state_d = S_IDLE;
      retry_d = '0;
      duty_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (tgt != D_STOP) begin
            state_d = S_DEAD;
            dir_d   = tgt;
            cnt_d   = '0;
          end
        end
        S_DEAD, S_RAMP, S_RUN: begin
          if (tgt == D_STOP) begin
            state_d = S_IDLE;
            duty_d  = '0;
            cnt_d   = '0;
          end else if (oc) begin
            state_d = S_FAULT;
            duty_d  = '0;
            cnt_d   = '0;
            retry_d = retry_q + RW'(1);
          end else if (tgt != dir_q) begin
            // direction flip always passes through a full dead time
            state_d = S_DEAD;
            dir_d   = tgt;
            duty_d  = '0;
            cnt_d   = '0;
          end else begin
            unique case (state_q)
              S_DEAD: begin
                if (cnt_q == CW'(DEAD_CYCLES - 1)) begin
                  state_d = S_RAMP;
                  duty_d  = '0;
                  cnt_d   = '0;
                end else cnt_d = cnt_q + CW'(1);
              end
              S_RAMP: begin
                if (duty_q >= dreq) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                end else if (cnt_q == CW'(RAMP_STEP_CYCLES - 1)) begin
                  duty_d = duty_q + 3'd1;
                  cnt_d  = '0;
                end else cnt_d = cnt_q + CW'(1);
              end
              default: begin
                // RUN: drop instantly, climb back through the ramp
                if (dreq < duty_q) duty_d = dreq;
                else if (dreq > duty_q) begin
                  state_d = S_RAMP;
                  cnt_d   = '0;
                end
              end
            endcase
          end
        end
        S_FAULT: begin
          if (cnt_q == CW'(FAULT_HOLD_CYCLES - 1)) begin
            state_d = (retry_q < RW'(MAX_RETRY)) ? S_IDLE : S_LOCKOUT;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_LOCKOUT: state_d = S_LOCKOUT;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // bridge pattern and drive gate registered from next state
  always_comb begin
    drive  = (state_d == S_RAMP) || (state_d == S_RUN);
    hb_d   = 4'b0000;
    if (drive) hb_d = (dir_d == D_FWD) ? 4'b1001 : 4'b0110;
    gate_d = drive && (duty_d != 3'd0);
  end

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= D_STOP;
      cnt_q   <= '0;
      duty_q  <= '0;
      retry_q <= '0;
      hb_q    <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      retry_q <= retry_d;
      hb_q    <= hb_d;
      gate_q  <= gate_d;
    end
  end

  assign state    = state_q;
  assign duty_cmd = duty_q;
  assign hb_in    = hb_q;
  assign en_a     = pwm_pulse & gate_q;
  assign en_b     = pwm_pulse & gate_q;
  assign fault    = (state_q == S_FAULT) || (state_q == S_LOCKOUT);
  assign lockout  = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: directed walk through the main scenarios plus
// randomized switch/comparator activity, all checked every cycle against a
// behavioural model of the sequencing rules.
module tb_motor_sequencer;
  localparam int DC = 4, RS = 8, FH = 16, CF = 3, MR = 2;
  localparam int IDLE = 0, DEAD = 1, RAMP = 2, RUN = 3, FLT = 4, LOCK = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, fwd_req = 1'b0, bwd_req = 1'b0;
  logic [2:0] duty_req = 3'd0;
  logic comp_a = 1'b0, comp_b = 1'b0, pwm_pulse = 1'b0;
  logic [2:0] duty_cmd, state;
  logic [3:0] hb_in;
  logic en_a, en_b, fault, lockout;

  motor_sequencer #(.DEAD_CYCLES(DC), .RAMP_STEP_CYCLES(RS), .FAULT_HOLD_CYCLES(FH),
                    .COMP_FILTER(CF), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fwd_req(fwd_req), .bwd_req(bwd_req),
    .duty_req(duty_req), .comp_a(comp_a), .comp_b(comp_b), .pwm_pulse(pwm_pulse),
    .duty_cmd(duty_cmd), .hb_in(hb_in), .en_a(en_a), .en_b(en_b), .fault(fault),
    .lockout(lockout), .state(state));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit hold_pwm = 1'b0, flip_seen = 1'b0;
  logic [3:0] prev_hb = 4'b0;

  // behavioural model: mode, latched direction, time in current phase
  int m_mode, m_dir, m_t, m_duty, m_retry, m_flt;
  bit [4:0] m_s1, m_s2; // {comp_b, comp_a, bwd, fwd, enable} as seen 1 and 2 edges late

  function automatic int target(bit f, bit b);
    if (f && !b) return 1;
    if (b && !f) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = IDLE; m_dir = 0; m_t = 0; m_duty = 0; m_retry = 0; m_flt = 0;
    m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_edge();
    bit en; int tgt; bit oc; int dreq;
    en = m_s2[0];
    tgt = target(m_s2[1], m_s2[2]);
    oc = (m_flt == CF);
    dreq = (duty_req > 4) ? 4 : int'(duty_req);
    if (!en) begin
      m_mode = IDLE; m_retry = 0; m_duty = 0;
    end else if (m_mode == IDLE) begin
      if (tgt != 0) begin m_mode = DEAD; m_dir = tgt; m_t = 0; end
    end else if (m_mode == DEAD || m_mode == RAMP || m_mode == RUN) begin
      if (tgt == 0) begin
        m_mode = IDLE; m_duty = 0;
      end else if (oc) begin
        m_mode = FLT; m_duty = 0; m_t = 0; m_retry++;
      end else if (tgt != m_dir) begin
        m_mode = DEAD; m_dir = tgt; m_duty = 0; m_t = 0;
      end else if (m_mode == DEAD) begin
        m_t++;
        if (m_t == DC) begin m_mode = RAMP; m_t = 0; m_duty = 0; end
      end else if (m_mode == RAMP) begin
        if (m_duty >= dreq) m_mode = RUN;
        else begin
          m_t++;
          if (m_t == RS) begin m_duty++; m_t = 0; end
        end
      end else begin
        if (dreq < m_duty) m_duty = dreq;
        else if (dreq > m_duty) begin m_mode = RAMP; m_t = 0; end
      end
    end else if (m_mode == FLT) begin
      m_t++;
      if (m_t == FH) m_mode = (m_retry < MR) ? IDLE : LOCK;
    end
    m_flt = (m_s2[3] | m_s2[4]) ? ((m_flt < CF) ? m_flt + 1 : CF) : 0;
    m_s2 = m_s1;
    m_s1 = {comp_b, comp_a, bwd_req, fwd_req, enable};
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task automatic chk_model();
    logic [3:0] hb;
    bit drv, g;
    drv = (m_mode == RAMP || m_mode == RUN);
    hb  = drv ? ((m_dir == 1) ? 4'b1001 : 4'b0110) : 4'b0000;
    g   = drv && (m_duty != 0) && pwm_pulse;
    chk("model", {18'd0, state, duty_cmd, hb_in, en_a, en_b, fault, lockout},
        {18'd0, 3'(m_mode), 3'(m_duty), hb, g, g, 1'(m_mode == FLT || m_mode == LOCK),
         1'(m_mode == LOCK)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    if (!hold_pwm) pwm_pulse = 1'($urandom_range(0, 1));
    #1;
    if ((prev_hb == 4'b1001 && hb_in == 4'b0110) || (prev_hb == 4'b0110 && hb_in == 4'b1001))
      flip_seen = 1'b1;
    prev_hb = hb_in;
    chk_model();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int dead_n, burst;
    model_reset();
    // reset state
    rst_n = 1'b0;
    ticks(2);
    chk("rst_state", state, 0);
    chk("rst_hb", hb_in, 0);
    rst_n = 1'b1;
    tick();

    // forward start with soft ramp to 3
    enable = 1; fwd_req = 1; duty_req = 3;
    dead_n = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (state == 3'd1) dead_n++; end
    chk("fwd_dead_len", dead_n, DC);
    chk("fwd_run", {state, duty_cmd, hb_in}, {3'd3, 3'd3, 4'b1001});

    // direction flip goes through dead time
    fwd_req = 0; bwd_req = 1;
    dead_n = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (state == 3'd1) dead_n++; end
    chk("flip_dead_len", dead_n, DC);
    chk("flip_direct", flip_seen, 0);
    chk("bwd_run", {state, duty_cmd, hb_in}, {3'd3, 3'd3, 4'b0110});

    // both requests -> stop
    fwd_req = 1;
    ticks(3);
    chk("both_stop", {state, hb_in, en_a, en_b}, {3'd0, 4'b0, 1'b0, 1'b0});
    fwd_req = 0;
    ticks(40);
    chk("bwd_run2", state, RUN);
    duty_req = 1;
    tick();
    chk("duty_drop", duty_cmd, 1);

    // short comparator pulse is filtered out
    comp_a = 1; ticks(2); comp_a = 0;
    ticks(8);
    chk("pulse_nofault", {state, fault}, {3'd3, 1'b0});

    // held comparator -> FAULT exactly at edge k+5
    comp_b = 1;
    ticks(5);
    chk("oc_before", state, RUN);
    tick();
    chk("oc_fault", {state, fault, hb_in, en_a}, {3'd4, 1'b1, 4'b0, 1'b0});
    comp_b = 0;
    ticks(FH);
    chk("retry_idle", state, IDLE);
    tick();
    chk("retry_dead", state, DEAD);
    ticks(DC);
    chk("retry_ramp", state, RAMP);

    // second overcurrent -> lockout, held until enable drops
    comp_b = 1; ticks(10); comp_b = 0;
    ticks(FH);
    chk("lockout", {state, lockout, fault}, {3'd5, 1'b1, 1'b1});
    ticks(10);
    chk("lock_hold", state, LOCK);
    enable = 0;
    ticks(3);
    chk("lock_clear", {state, lockout}, {3'd0, 1'b0});
    enable = 1;
    ticks(3 + DC + RS + 2);
    chk("restart_run", state, RUN);
    comp_b = 1; ticks(6); comp_b = 0;
    chk("fault_again", state, FLT);
    ticks(FH);
    chk("retry_cleared", state, IDLE);

    // async reset during RAMP with the bridge driven
    duty_req = 3;
    ticks(1 + DC + RS);
    hold_pwm = 1'b1; pwm_pulse = 1'b1;
    #1;
    chk("ramp_drive", {state, duty_cmd, en_a}, {3'd2, 3'd1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("async_rst", {hb_in, en_a, en_b}, {4'b0, 1'b0, 1'b0});
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst", state, IDLE);
    hold_pwm = 1'b0;

    // randomized operation
    burst = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
      if ($urandom_range(0, 59) == 0) fwd_req = ~fwd_req;
      if ($urandom_range(0, 59) == 0) bwd_req = ~bwd_req;
      if ($urandom_range(0, 39) == 0) duty_req = 3'($urandom_range(0, 7));
      if (burst > 0) begin
        burst--;
        if ($urandom_range(0, 1) == 0) begin comp_a = 1; comp_b = 0; end
        else begin comp_a = 0; comp_b = 1; end
      end else begin
        comp_a = 0; comp_b = 0;
        if ($urandom_range(0, 99) == 0) burst = $urandom_range(1, 6);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
